// File: rtl/centroid_div_sched.sv
// rtl/centroid_div_sched.sv - frame-synchronous scheduler for a shared centroid divider
//
// Captures per-frame pixel count and coordinate sums on frame_done, issues
// sum_x/size then sum_y/size to one shared divider, and publishes a saturated
// (x, y) centroid with a one-cycle valid strobe.
//
// Optional feature macro: CENTROID_SMOOTH_EN (publish the average of the old
// and new centroid; the first publish after reset or a lost frame loads the
// new centroid directly).
//
// Ports:
//   clk_65mhz, reset        clock, synchronous active-high reset
//   frame_done              one-cycle end-of-accumulation pulse
//   size_in/sum_x_in/sum_y_in  accumulated pixel count and coordinate sums
//   div_dividend/div_divisor/div_tvalid  request to the shared divider
//   div_dout_tvalid/div_quotient         result from the shared divider
//   x_mean/y_mean/mean_valid centroid outputs and update strobe
//   lost                     last frame was too small or the divider timed out
//   busy                     scheduler is not idle
//   drop_count               saturating count of frame_done pulses ignored while busy
module centroid_div_sched #(
  parameter int MIN_SIZE = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk_65mhz,
  input  logic        reset,
  input  logic        frame_done,
  input  logic [31:0] size_in,
  input  logic [31:0] sum_x_in,
  input  logic [31:0] sum_y_in,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_tvalid,
  input  logic        div_dout_tvalid,
  input  logic [31:0] div_quotient,
  output logic [10:0] x_mean,
  output logic [9:0]  y_mean,
  output logic        mean_valid,
  output logic        lost,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, REQ_X, WAIT_X, REQ_Y, WAIT_Y, PUBLISH
  } state_t;

  state_t state, state_next;

  logic [31:0]   size_r, sum_x_r, sum_y_r;
  logic [31:0]   x_q, y_q;
  logic [CW-1:0] tmo_cnt;
  logic          timed_out;
  logic          too_small;
  logic [10:0]   x_sat;
  logic [9:0]    y_sat;

  // tmo_cnt counts cycles elapsed since the request strobe, so the abort
  // lands TIMEOUT cycles after the request was issued.
  assign timed_out = (tmo_cnt >= CW'(TIMEOUT - 1));
  assign too_small = (size_r < 32'(MIN_SIZE));
  assign x_sat     = (x_q > 32'd2047) ? 11'h7FF : x_q[10:0];
  assign y_sat     = (y_q > 32'd1023) ? 10'h3FF : y_q[9:0];

`ifdef CENTROID_SMOOTH_EN
  logic        have_mean;
  logic [11:0] x_sum;
  logic [10:0] y_sum;
  assign x_sum = {1'b0, x_mean} + {1'b0, x_sat};
  assign y_sum = {1'b0, y_mean} + {1'b0, y_sat};
`endif

  always_ff @(posedge clk_65mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_tvalid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (frame_done) state_next = LATCH;
      LATCH:   state_next = too_small ? IDLE : REQ_X;
      REQ_X: begin
        div_tvalid = 1'b1;
        state_next = WAIT_X;
      end
      WAIT_X: begin
        if (div_dout_tvalid) state_next = REQ_Y;
        else if (timed_out)  state_next = IDLE;
      end
      REQ_Y: begin
        div_tvalid = 1'b1;
        state_next = WAIT_Y;
      end
      WAIT_Y: begin
        if (div_dout_tvalid) state_next = PUBLISH;
        else if (timed_out)  state_next = IDLE;
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      size_r       <= '0;
      sum_x_r      <= '0;
      sum_y_r      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      tmo_cnt      <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      x_mean       <= '0;
      y_mean       <= '0;
      mean_valid   <= 1'b0;
      lost         <= 1'b0;
      drop_count   <= '0;
`ifdef CENTROID_SMOOTH_EN
      have_mean    <= 1'b0;
`endif
    end else begin
      mean_valid <= 1'b0;
      if (state != IDLE && frame_done && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: begin
          if (frame_done) begin
            size_r  <= size_in;
            sum_x_r <= sum_x_in;
            sum_y_r <= sum_y_in;
          end
        end
        LATCH: begin
          if (too_small) begin
            lost <= 1'b1;
`ifdef CENTROID_SMOOTH_EN
            have_mean <= 1'b0;
`endif
          end else begin
            // operands are staged here so they are stable during the strobe
            div_dividend <= sum_x_r;
            div_divisor  <= size_r;
          end
        end
        REQ_X, REQ_Y: tmo_cnt <= CW'(1);
        WAIT_X, WAIT_Y: begin
          if (div_dout_tvalid) begin
            if (state == WAIT_X) begin
              x_q          <= div_quotient;
              div_dividend <= sum_y_r;
            end else begin
              y_q <= div_quotient;
            end
          end else if (timed_out) begin
            lost <= 1'b1;
`ifdef CENTROID_SMOOTH_EN
            have_mean <= 1'b0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        PUBLISH: begin
`ifdef CENTROID_SMOOTH_EN
          x_mean    <= have_mean ? x_sum[11:1] : x_sat;
          y_mean    <= have_mean ? y_sum[10:1] : y_sat;
          have_mean <= 1'b1;
`else
          x_mean <= x_sat;
          y_mean <= y_sat;
`endif
          lost       <= 1'b0;
          mean_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_div_sched.sv
// tb/tb_centroid_div_sched.sv - scoreboard testbench for centroid_div_sched
module tb_centroid_div_sched;

  logic        clk_65mhz = 1'b0;
  logic        reset;
  logic        frame_done;
  logic [31:0] size_in, sum_x_in, sum_y_in;
  logic [31:0] div_dividend, div_divisor;
  logic        div_tvalid;
  logic        div_dout_tvalid;
  logic [31:0] div_quotient;
  logic [10:0] x_mean;
  logic [9:0]  y_mean;
  logic        mean_valid, lost, busy;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
  } exp_t;
  exp_t exp_q[$];

  // expected published centroid, tracked by the bench
  logic [10:0] mdl_x = '0;
  logic [9:0]  mdl_y = '0;
  bit          mdl_have = 0;

  // divider model controls
  bit          div_en = 1;
  int          div_lat = 5;
  int          div_cnt = 0;
  logic [31:0] div_res = '0;

  centroid_div_sched #(.MIN_SIZE(16), .TIMEOUT(64)) dut (
    .clk_65mhz      (clk_65mhz),
    .reset          (reset),
    .frame_done     (frame_done),
    .size_in        (size_in),
    .sum_x_in       (sum_x_in),
    .sum_y_in       (sum_y_in),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_tvalid     (div_tvalid),
    .div_dout_tvalid(div_dout_tvalid),
    .div_quotient   (div_quotient),
    .x_mean         (x_mean),
    .y_mean         (y_mean),
    .mean_valid     (mean_valid),
    .lost           (lost),
    .busy           (busy),
    .drop_count     (drop_count)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_65mhz);
  endtask

  // new centroid from the bench's own division and saturation
  task automatic expect_publish(input logic [31:0] s, input logic [31:0] sx, input logic [31:0] sy);
    logic [31:0] qx, qy;
    logic [10:0] nx;
    logic [9:0]  ny;
    exp_t e;
    qx = sx / s;
    qy = sy / s;
    nx = (qx > 2047) ? 11'd2047 : qx[10:0];
    ny = (qy > 1023) ? 10'd1023 : qy[9:0];
`ifdef CENTROID_SMOOTH_EN
    if (mdl_have) begin
      nx = 11'((12'(mdl_x) + 12'(nx)) >> 1);
      ny = 10'((11'(mdl_y) + 11'(ny)) >> 1);
    end
`endif
    mdl_x = nx;
    mdl_y = ny;
    mdl_have = 1;
    e.x = nx;
    e.y = ny;
    exp_q.push_back(e);
  endtask

  // drives frame_done during cycle 0 and returns at cycle 1
  task automatic pulse(input logic [31:0] s, input logic [31:0] sx, input logic [31:0] sy);
    size_in = s;
    sum_x_in = sx;
    sum_y_in = sy;
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
  endtask

  // divider: result strobe div_lat cycles after the request
  initial begin
    div_dout_tvalid = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk_65mhz);
      div_dout_tvalid = 1'b0;
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          div_dout_tvalid = 1'b1;
          div_quotient = div_res;
        end
      end
      if (div_tvalid && div_en) begin
        div_cnt = div_lat;
        div_res = (div_divisor != 0) ? div_dividend / div_divisor : 32'd0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_65mhz);
      if (mean_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mean_valid actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("x_mean", x_mean, e.x);
          check("y_mean", y_mean, e.y);
          check("lost_at_publish", lost, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    frame_done = 1'b0;
    size_in = '0;
    sum_x_in = '0;
    sum_y_in = '0;
    cyc(3);
    check("rst_x_mean", x_mean, 0);
    check("rst_y_mean", y_mean, 0);
    check("rst_lost", lost, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_valid", mean_valid, 0);
    check("rst_tvalid", div_tvalid, 0);
    reset = 1'b0;
    cyc(2);

    // nominal frame, divider latency 5
    expect_publish(100, 32000, 24000);
    pulse(100, 32000, 24000);
    check("t1_busy_c1", busy, 1);
    check("t1_tvalid_c1", div_tvalid, 0);
    cyc(1);
    check("t1_tvalid_c2", div_tvalid, 1);
    check("t1_dividend_x", div_dividend, 32000);
    check("t1_divisor_x", div_divisor, 100);
    cyc(1);
    check("t1_tvalid_c3", div_tvalid, 0);
    cyc(5);
    check("t1_tvalid_c8", div_tvalid, 1);
    check("t1_dividend_y", div_dividend, 24000);
    cyc(6);
    check("t1_valid_c14", mean_valid, 0);
    check("t1_busy_c14", busy, 1);
    cyc(1);
    check("t1_valid_c15", mean_valid, 1);
    check("t1_busy_c15", busy, 0);
    cyc(3);

    // below MIN_SIZE
    pulse(10, 1000, 1000);
    check("t2_busy_c1", busy, 1);
    check("t2_tvalid_c1", div_tvalid, 0);
    cyc(1);
    mdl_have = 0;
    check("t2_busy_c2", busy, 0);
    check("t2_lost", lost, 1);
    check("t2_tvalid_c2", div_tvalid, 0);
    check("t2_x_hold", x_mean, mdl_x);
    check("t2_y_hold", y_mean, mdl_y);
    cyc(3);

    // saturation boundaries, smallest accepted size
    for (int i = 0; i < 3; i++) begin
      logic [31:0] tsx [3];
      logic [31:0] tsy [3];
      tsx = '{80000, 32752, 32736};
      tsy = '{20000, 16384, 16368};
      expect_publish(16, tsx[i], tsy[i]);
      pulse(16, tsx[i], tsy[i]);
      cyc(19);
    end

    // divider never answers
    div_en = 0;
    pulse(100, 32000, 24000);
    cyc(1);
    check("t3_tvalid_c2", div_tvalid, 1);
    cyc(63);
    check("t3_busy_c65", busy, 1);
    cyc(1);
    mdl_have = 0;
    check("t3_busy_c66", busy, 0);
    check("t3_lost", lost, 1);
    check("t3_x_hold", x_mean, mdl_x);
    div_en = 1;
    cyc(2);

    // frame_done while busy is dropped and operands are preserved
    expect_publish(200, 40000, 30000);
    pulse(200, 40000, 30000);
    cyc(3);
    size_in = 50;
    sum_x_in = 7;
    sum_y_in = 9;
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    check("t4_drop_1", drop_count, 1);
    cyc(3);
    check("t4_dividend_y", div_dividend, 30000);
    check("t4_divisor_y", div_divisor, 200);
    cyc(12);
    check("t4_lost_clear", lost, 0);

    // drop_count saturation with small frames
    size_in = 5;
    frame_done = 1'b1;
    cyc(520);
    frame_done = 1'b0;
    cyc(3);
    mdl_have = 0;
    check("t4_drop_sat", drop_count, 255);
    check("t4_lost_small", lost, 1);

    // reset in the middle of a computation
    pulse(100, 32000, 24000);
    cyc(7);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    mdl_have = 0;
    mdl_x = '0;
    mdl_y = '0;
    check("t6_busy", busy, 0);
    check("t6_x_mean", x_mean, 0);
    check("t6_y_mean", y_mean, 0);
    check("t6_lost", lost, 0);
    check("t6_drop", drop_count, 0);
    check("t6_tvalid", div_tvalid, 0);
    check("t6_dividend", div_dividend, 0);
    cyc(6);
    check("t6_busy_after_late", busy, 0);
    check("t6_x_after_late", x_mean, 0);
    cyc(3);

    // recovery after reset
    expect_publish(100, 32000, 24000);
    pulse(100, 32000, 24000);
    cyc(19);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
